// File: rtl/hex_scan_if.sv
// Request, decoder and display signals of the four-digit hex scan controller.
interface hex_scan_if;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  dec_nibble;
  logic [6:0]  dec_seg;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic        busy;
  logic        done;

  // Host side: issues requests, hosts the external decoder, watches the display.
  modport master (
    output load, value, blank_lz, dec_seg,
    input  dec_nibble, hex0, hex1, hex2, hex3, busy, done
  );

  // Controller side.
  modport slave (
    input  load, value, blank_lz, dec_seg,
    output dec_nibble, hex0, hex1, hex2, hex3, busy, done
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Four-digit hex display refresher time-sharing one external 7-segment decoder.
// Each digit takes an ISSUE/CAPTURE pair; decoded segments pass through an
// output register stage so the displayed digits and the done pulse line up.
module hex_scan_ctrl #(
  parameter logic [6:0] BLANK_PAT = 7'h7F
) (
  input  logic      clk,
  input  logic      rst,
  hex_scan_if.slave bus
);
  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned VAL_W = 16;
  localparam int unsigned N_DIG = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic             blank_lz;
  } req_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  req_t             r_shadow, w_shadow_nxt;
  req_t             r_pend, w_pend_nxt;
  logic             r_pend_vld, w_pend_vld_nxt;
  logic [NIB_W-1:0] r_dec_nibble, w_dec_nibble_nxt;
  logic [SEG_W-1:0] r_seg [N_DIG];
  logic [SEG_W-1:0] w_seg_nxt [N_DIG];
  logic [SEG_W-1:0] r_hex [N_DIG];
  logic             r_busy;
  logic             r_done;

  req_t             w_load_req;
  logic [NIB_W-1:0] w_cur_nib;
  logic             w_upper_zero;
  logic             w_blank;

  assign w_load_req = req_t'({bus.value, bus.blank_lz});
  assign w_cur_nib  = r_shadow.value[{r_idx, 2'b00} +: NIB_W];
  assign w_blank    = r_shadow.blank_lz & w_upper_zero;

  // Current digit and everything above it are zero (never true for digit 0).
  always_comb begin
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd1:    w_upper_zero = (r_shadow.value[15:4]  == 12'h000);
      2'd2:    w_upper_zero = (r_shadow.value[15:8]  == 8'h00);
      2'd3:    w_upper_zero = (r_shadow.value[15:12] == 4'h0);
      default: w_upper_zero = 1'b0;
    endcase
  end

  // Next-state and datapath next values.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_shadow_nxt     = r_shadow;
    w_pend_nxt       = r_pend;
    w_pend_vld_nxt   = r_pend_vld;
    w_dec_nibble_nxt = r_dec_nibble;
    w_seg_nxt        = r_seg;

    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_shadow_nxt = w_load_req;
          w_idx_nxt    = 2'd0;
          w_state_nxt  = ISSUE;
        end else if (r_pend_vld) begin
          // A request that arrived in the DONE cycle with nothing queued.
          w_shadow_nxt   = r_pend;
          w_pend_vld_nxt = 1'b0;
          w_idx_nxt      = 2'd0;
          w_state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        w_dec_nibble_nxt = w_cur_nib;
        w_state_nxt      = CAPTURE;
      end
      CAPTURE: begin
        w_seg_nxt[r_idx] = w_blank ? BLANK_PAT : bus.dec_seg;
        if (r_idx == 2'd3) begin
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = ISSUE;
        end
      end
      DONE: begin
        if (r_pend_vld) begin
          w_shadow_nxt   = r_pend;
          w_pend_vld_nxt = 1'b0;
          w_idx_nxt      = 2'd0;
          w_state_nxt    = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Loads while busy queue up; the newest one wins, even in the DONE cycle.
    if (bus.load && (r_state != IDLE)) begin
      w_pend_nxt     = w_load_req;
      w_pend_vld_nxt = 1'b1;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      r_shadow     <= '0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
      r_dec_nibble <= 4'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
        r_seg[i] <= BLANK_PAT;
        r_hex[i] <= BLANK_PAT;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_shadow     <= w_shadow_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_dec_nibble <= w_dec_nibble_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (r_state == DONE);
      for (int i = 0; i < N_DIG; i++) begin
        r_seg[i] <= w_seg_nxt[i];
        r_hex[i] <= r_seg[i];
      end
    end
  end

  assign bus.dec_nibble = r_dec_nibble;
  assign bus.hex0       = r_hex[0];
  assign bus.hex1       = r_hex[1];
  assign bus.hex2       = r_hex[2];
  assign bus.hex3       = r_hex[3];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

  // Protocol invariants.
  a_busy_state: assert property (@(posedge clk) disable iff (rst)
    r_busy == (r_state != IDLE));
  a_done_single: assert property (@(posedge clk) disable iff (rst)
    r_done |=> !r_done);
  a_nib_stable: assert property (@(posedge clk) disable iff (rst)
    (r_state == CAPTURE) |=> $stable(r_dec_nibble));

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with a behavioural hex-to-7-segment decoder.
module tb_hex_scan_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hex_scan_if bus ();

  hex_scan_ctrl #(.BLANK_PAT(7'h7F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [6:0]  h3, h2, h1, h0;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  logic [6:0] prev [4];

  // Active-low gfedcba decoder standing in for the external part.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign bus.dec_seg = seg7(bus.dec_nibble);

  always @(negedge clk) if (!rst && bus.done) n_done++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_hex(input string name, input logic [6:0] h3, input logic [6:0] h2,
                         input logic [6:0] h1, input logic [6:0] h0);
    chk({name, ".hex3"}, 16'(bus.hex3), 16'(h3));
    chk({name, ".hex2"}, 16'(bus.hex2), 16'(h2));
    chk({name, ".hex1"}, 16'(bus.hex1), 16'(h1));
    chk({name, ".hex0"}, 16'(bus.hex0), 16'(h0));
  endtask

  // One full refresh from IDLE with cycle-exact checks relative to the load edge N.
  task automatic do_refresh(input vec_t v, input string name);
    int d0;
    @(posedge clk); #1;
    bus.load = 1'b1; bus.value = v.value; bus.blank_lz = v.blz;
    @(posedge clk); #1;
    bus.load = 1'b0;
    d0 = n_done;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk({name, ".busy_start"}, 16'(bus.busy), 16'd1);
      if (k == 2) chk({name, ".hex0_hold"}, 16'(bus.hex0), 16'(prev[0]));
      if (k == 3) begin
        chk({name, ".hex0_early"}, 16'(bus.hex0), 16'(v.h0));
        chk({name, ".hex1_hold"}, 16'(bus.hex1), 16'(prev[1]));
      end
      if (k == 8) chk({name, ".done_early"}, 16'(bus.done), 16'd0);
      if (k == 9) begin
        chk_hex(name, v.h3, v.h2, v.h1, v.h0);
        chk({name, ".done"}, 16'(bus.done), 16'd1);
      end
      if (k == 10) begin
        chk({name, ".done_fall"}, 16'(bus.done), 16'd0);
        chk({name, ".busy_end"}, 16'(bus.busy), 16'd0);
      end
    end
    chk({name, ".done_count"}, 16'(n_done - d0), 16'd1);
    prev[0] = v.h0; prev[1] = v.h1; prev[2] = v.h2; prev[3] = v.h3;
  endtask

  // 1111 then 2222/000F while busy; optional extra load in the DONE cycle.
  task automatic pend_seq(input logic third, input string name);
    int d0;
    int last;
    @(posedge clk); #1;
    bus.load = 1'b1; bus.value = 16'h1111; bus.blank_lz = 1'b1;
    @(posedge clk); #1;                 // after edge N
    d0 = n_done;
    bus.value = 16'h2222;
    @(posedge clk); #1;                 // after N+1
    bus.value = 16'h000F;
    @(posedge clk); #1;                 // after N+2
    bus.load = 1'b0;
    last = third ? 32 : 22;
    for (int k = 3; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == 9) begin
        chk_hex({name, ".first"}, 7'h79, 7'h79, 7'h79, 7'h79);
        chk({name, ".done1"}, 16'(bus.done), 16'd1);
        chk({name, ".busy_chain"}, 16'(bus.busy), 16'd1);
      end
      if (k == 17) chk({name, ".hex3_hold"}, 16'(bus.hex3), 16'h79);
      if (k == 18) begin
        chk_hex({name, ".second"}, 7'h7F, 7'h7F, 7'h7F, 7'h0E);
        chk({name, ".done2"}, 16'(bus.done), 16'd1);
      end
      if (third && k == 27) begin
        chk_hex({name, ".third"}, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        chk({name, ".done3"}, 16'(bus.done), 16'd1);
      end
      if (third && k == 8) begin
        bus.load = 1'b1; bus.value = 16'h0000; bus.blank_lz = 1'b1;
      end
      if (third && k == 9) bus.load = 1'b0;
    end
    chk({name, ".busy_idle"}, 16'(bus.busy), 16'd0);
    chk({name, ".done_count"}, 16'(n_done - d0), third ? 16'd3 : 16'd2);
    if (third) begin
      prev[0] = 7'h40; prev[1] = 7'h7F; prev[2] = 7'h7F; prev[3] = 7'h7F;
    end else begin
      prev[0] = 7'h0E; prev[1] = 7'h7F; prev[2] = 7'h7F; prev[3] = 7'h7F;
    end
  endtask

  vec_t vecs [9];

  initial begin
    int d0;
    vecs[0] = '{16'h1234, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19};
    vecs[1] = '{16'h00A0, 1'b1, 7'h7F, 7'h7F, 7'h08, 7'h40};
    vecs[2] = '{16'h00A0, 1'b0, 7'h40, 7'h40, 7'h08, 7'h40};
    vecs[3] = '{16'h0000, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[4] = '{16'h000F, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h0E};
    vecs[5] = '{16'h0F00, 1'b1, 7'h7F, 7'h0E, 7'h40, 7'h40};
    vecs[6] = '{16'hFEDC, 1'b1, 7'h0E, 7'h06, 7'h21, 7'h46};
    vecs[7] = '{16'h5678, 1'b0, 7'h12, 7'h02, 7'h78, 7'h00};
    vecs[8] = '{16'h0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40};

    rst = 1'b1;
    bus.load = 1'b0; bus.value = 16'h0000; bus.blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_hex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("reset.busy", 16'(bus.busy), 16'd0);
    chk("reset.done", 16'(bus.done), 16'd0);
    chk("reset.dec_nibble", 16'(bus.dec_nibble), 16'h0);
    for (int i = 0; i < 4; i++) prev[i] = 7'h7F;

    for (int i = 0; i < 9; i++) do_refresh(vecs[i], $sformatf("vec%0d", i));

    pend_seq(1'b0, "pend");
    pend_seq(1'b1, "pend_done_cycle");

    // Mid-refresh reset at edge N+4, with a competing load at that edge.
    @(posedge clk); #1;
    bus.load = 1'b1; bus.value = 16'h4321; bus.blank_lz = 1'b0;
    @(posedge clk); #1;                 // after edge N
    bus.load = 1'b0;
    d0 = n_done;
    repeat (3) @(posedge clk);          // N+1..N+3
    #1;
    rst = 1'b1; bus.load = 1'b1; bus.value = 16'hFFFF;
    @(posedge clk); #1;                 // after N+4
    rst = 1'b0; bus.load = 1'b0;
    chk_hex("midrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("midrst.busy", 16'(bus.busy), 16'd0);
    chk("midrst.dec_nibble", 16'(bus.dec_nibble), 16'h0);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst.no_done", 16'(n_done - d0), 16'd0);
    chk("midrst.busy_after", 16'(bus.busy), 16'd0);
    chk_hex("midrst.held", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    for (int i = 0; i < 4; i++) prev[i] = 7'h7F;
    do_refresh(vecs[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter BLANK_PAT, default 7'h7F, the active-low segment pattern driven for a blank digit (all segments off).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load  input  1  request to display a new value; sampled every clk edge.
REQ-005 SHALL have port value  input  16  four hex digits; value[3:0] is digit 0 (rightmost).
REQ-006 SHALL have port blank_lz  input  1  leading-zero blanking enable; captured together with value.
REQ-007 SHALL have port dec_nibble  output  4  nibble presented to the shared external hex-to-7-segment decoder.
REQ-008 SHALL have port dec_seg  input  7  active-low segment code returned combinationally by that decoder for dec_nibble.
REQ-009 SHALL have ports hex0, hex1, hex2, hex3  output  7 each  registered active-low segment drives, digit 0..3.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when all four digits have been refreshed.

Function
REQ-012 SHALL implement states IDLE, ISSUE, CAPTURE, DONE with a 2-bit digit index idx.
REQ-013 IDLE with load=1 SHALL capture value/blank_lz into a shadow register, set idx=0, and go to ISSUE.
REQ-014 ISSUE SHALL register dec_nibble <= shadow[4*idx+3:4*idx] and go to CAPTURE; dec_nibble SHALL stay stable throughout CAPTURE.
REQ-015 CAPTURE SHALL write hex[idx] <= dec_seg, or BLANK_PAT if the digit is blanked; if idx==3, go to DONE, else idx++ and go to ISSUE.
REQ-016 A digit idx SHALL be blanked iff shadow blank_lz=1, idx!=0, and all shadow nibbles idx..3 are zero; digit 0 SHALL never be blanked.
REQ-017 DONE SHALL assert done for exactly that one cycle, then go to ISSUE (idx=0) if pending is set, else to IDLE.
REQ-018 Timing: with load sampled at edge N in IDLE, hex0 SHALL update at edge N+3, hex1 at N+5, hex2 at N+7, hex3 at N+9; done SHALL be high in the cycle after N+9.
REQ-019 hex outputs not yet rewritten SHALL hold their previous values during a refresh; no other output glitches are permitted.
REQ-020 load while busy (including the DONE cycle) SHALL store value/blank_lz into a pending register and set pending; a later load SHALL overwrite it, so the latest value wins.
REQ-021 On leaving DONE with pending set, SHALL move pending into shadow, clear pending, and start a full refresh; the refresh in progress SHALL NOT be aborted.
REQ-022 load and the DONE-to-ISSUE move in the same cycle SHALL leave the new value pending for the following refresh.

Reset
REQ-023 rst=1 at a clk edge SHALL force IDLE, idx=0, pending=0, shadow=0, dec_nibble=4'h0, busy=0, done=0, and hex0..hex3=BLANK_PAT.
REQ-024 rst SHALL override load in the same cycle, and a mid-refresh reset SHALL abandon the refresh with no done pulse.

Verification
REQ-025 load value=16'h1234, blank_lz=0, with the real decoder -> hex3=7'h79, hex2=7'h24, hex1=7'h30, hex0=7'h19; one done pulse 9 cycles after load.
REQ-026 load value=16'h00A0, blank_lz=1 -> hex3=7'h7F, hex2=7'h7F, hex1=7'h08, hex0=7'h40; with blank_lz=0 -> hex3=hex2=7'h40.
REQ-027 load value=16'h0000, blank_lz=1 -> hex0=7'h40, hex1..hex3=7'h7F.
REQ-028 load 16'h1111, then load 16'h2222 and 16'h000F while busy -> first refresh completes with 1s, then exactly one more refresh shows 7'h7F,7'h7F,7'h7F,7'h0E (blank_lz=1); exactly two done pulses.
REQ-029 rst asserted for 1 cycle at edge N+4 after a load -> busy=0, done never pulses, hex0..hex3=7'h7F; a subsequent load refreshes normally.
REQ-030 Assertions: busy==(state!=IDLE), done is never high for two consecutive cycles, and dec_nibble is constant during each CAPTURE cycle.
